uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the single UART transmit channel (tx/txce/is_transmitting) between two word-wide requesters.
//   Typical requesters: the nonce result path (req[0]) and a status/diagnostic reporter (req[1]).
//   Each granted request is sent as one frame: a per-requester tag byte, then the data word MSB byte first.
//   Handshake: req/ack per requester. Transmit is held off while the UART is receiving (half-duplex policy).
// PARAMETERS
//   WORD_BYTES     4      data bytes per frame (>=1); data word width = WORD_BYTES*8
//   TAG0           8'hA5  tag byte sent first in every requester-0 frame
//   TAG1           8'h5A  tag byte sent first in every requester-1 frame
//   START_TIMEOUT  16     max cycles to wait for is_transmitting to rise after a txce pulse (>=2)
// PORTS
//   clock            in   1              system clock, all state on posedge
//   reset            in   1              asynchronous, active-high reset
//   req              in   2              level request per requester; held until ack (or dropped to withdraw while idle)
//   data0            in   WORD_BYTES*8   requester-0 word; sampled only on the grant cycle
//   data1            in   WORD_BYTES*8   requester-1 word; sampled only on the grant cycle
//   ack              out  2              one-cycle pulse on bit i when requester i's frame is fully sent
//   tx               out  8              byte to UART; stable from txce pulse until next byte loaded
//   txce             out  1              one-cycle transmit strobe to UART (registered)
//   is_transmitting  in   1              UART busy shifting a byte
//   is_receiving     in   1              UART busy receiving; blocks new txce issue
//   busy             out  1              high in every state except IDLE
//   timeout_err      out  1              one-cycle pulse when a byte fails to start within START_TIMEOUT
// BEHAVIOUR
//   Reset (async): state=IDLE; ack=0, tx=8'h00, txce=0, busy=0, timeout_err=0; last_grant=1; byte/timeout counters=0.
//   States: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> (ISSUE | DONE); DONE -> IDLE.
//   IDLE: if req!=0, grant. Single request: that one. Both: the one != last_grant (round robin).
//     On grant: shift_reg <= {TAGi, datai}; remaining = WORD_BYTES+1; last_grant <= i; go ISSUE.
//   ISSUE: if is_receiving==1, wait here with txce=0.
//     Otherwise: tx <= shift_reg MSB byte; shift_reg <<= 8; txce=1 for exactly this one cycle.
//     Then timeout counter <= 0; go WAIT_START.
//   WAIT_START: if is_transmitting==1 -> WAIT_DONE.
//     Otherwise count; when count reaches START_TIMEOUT: pulse timeout_err, abort the frame, go IDLE.
//     Abort means no ack and the data is discarded.
//     req is still high, so the whole frame is re-arbitrated and resent from the tag byte.
//   WAIT_DONE: on is_transmitting==0: remaining-=1; if remaining!=0 -> ISSUE, else -> DONE.
//   DONE: ack[granted]=1 for one cycle; go IDLE.
//     Requester must clear req on the edge where it sees ack. IDLE samples req the cycle after ack.
//   Latency: req seen in IDLE at edge n -> txce high in cycle n+1 (if is_receiving=0).
//     Minimum frame = (WORD_BYTES+1) byte times + 3*(WORD_BYTES+1) + 2 cycles of overhead.
//   txce never asserts in two consecutive cycles. txce never asserts while is_transmitting or is_receiving is 1.
//   req change mid-frame: ignored; the granted data was captured at grant and the frame completes.
//   Reset mid-frame: outputs return to reset values immediately (txce drops asynchronously); the frame is lost; no ack.
//   Bytes on the wire per frame: TAGi, data[W*8-1 -: 8], ..., data[7:0].
// TESTING
//   1. req=2'b01, data0=32'h12345678, UART model: 3-cycle start delay, 20-cycle byte
//      -> bytes A5,12,34,56,78 -> ack[0] one pulse -> back to IDLE.
//   2. req=2'b11 from reset, data1=32'hDEADBEEF
//      -> frame0 first (last_grant=1 at reset), then A5.. then 5A,DE,AD,BE,EF; ack[0] then ack[1].
//   3. is_receiving=1 held 50 cycles at an ISSUE point
//      -> txce stays 0 throughout; the byte issues the cycle after is_receiving falls; no byte lost.
//   4. UART model never raises is_transmitting on the 2nd byte
//      -> timeout_err pulse START_TIMEOUT cycles after txce; no ack; frame restarts with tag A5.
//   5. Assert reset during the 3rd byte of a frame
//      -> txce/ack/busy=0 at once; after release, req=01 still high -> full frame resent from A5.
//   6. Checker over all tests: txce pulses are 1 cycle, never back-to-back, never while is_transmitting=1;
//      exactly one ack per completed frame.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Bundles the requester handshake and UART-side signals of uart_tx_scheduler.
// The scheduler is the slave; whatever drives requests and models the UART is the master.
interface uart_tx_scheduler_if #(
    parameter int unsigned WORD_BYTES = 4
);
    logic [1:0]              req;
    logic [WORD_BYTES*8-1:0] data0;
    logic [WORD_BYTES*8-1:0] data1;
    logic [1:0]              ack;
    logic [7:0]              tx;
    logic                    txce;
    logic                    is_transmitting;
    logic                    is_receiving;
    logic                    busy;
    logic                    timeout_err;

    modport slave (
        input  req, data0, data1, is_transmitting, is_receiving,
        output ack, tx, txce, busy, timeout_err
    );

    modport master (
        output req, data0, data1, is_transmitting, is_receiving,
        input  ack, tx, txce, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between two word-wide requesters.
// Each grant sends a tag byte followed by the data word, MSB byte first.
module uart_tx_scheduler #(
    parameter int unsigned WORD_BYTES    = 4,
    parameter logic [7:0]  TAG0          = 8'hA5,
    parameter logic [7:0]  TAG1          = 8'h5A,
    parameter int unsigned START_TIMEOUT = 16
) (
    input logic clock,
    input logic reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int unsigned FRAME_BITS = (WORD_BYTES + 1) * 8;
    localparam int unsigned REM_W      = $clog2(WORD_BYTES + 2);
    localparam int unsigned TO_W       = $clog2(START_TIMEOUT + 1);
    localparam logic [REM_W-1:0] FRAME_BYTES = REM_W'(WORD_BYTES + 1);
    localparam logic [REM_W-1:0] LAST_BYTE   = REM_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        DONE
    } state_t;

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [REM_W-1:0]      r_remaining;
    logic [TO_W-1:0]       r_timeoutCnt;
    logic                  r_lastGrant;
    logic                  r_granted;
    logic [1:0]            r_ack;
    logic [7:0]            r_tx;
    logic                  r_txce;
    logic                  r_timeoutErr;

    logic                  w_grantIdx;

    // Two simultaneous requests go to whoever was not served last.
    always_comb begin
        w_grantIdx = 1'b0;
        case (bus.req)
            2'b10:   w_grantIdx = 1'b1;
            2'b11:   w_grantIdx = ~r_lastGrant;
            default: w_grantIdx = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_remaining  <= '0;
            r_timeoutCnt <= '0;
            r_lastGrant  <= 1'b1;
            r_granted    <= 1'b0;
            r_ack        <= 2'b00;
            r_tx         <= 8'h00;
            r_txce       <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_txce       <= 1'b0;
            r_ack        <= 2'b00;
            r_timeoutErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    // While ack is still visible the requester has not yet dropped req.
                    if ((bus.req != 2'b00) && (r_ack == 2'b00)) begin
                        r_granted   <= w_grantIdx;
                        r_lastGrant <= w_grantIdx;
                        r_shift     <= w_grantIdx ? {TAG1, bus.data1} : {TAG0, bus.data0};
                        r_remaining <= FRAME_BYTES;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.is_receiving) begin
                        r_tx         <= r_shift[FRAME_BITS-1 -: 8];
                        r_shift      <= r_shift << 8;
                        r_txce       <= 1'b1;
                        r_timeoutCnt <= '0;
                        r_state      <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    // A byte that never starts aborts the frame; the held req retries it from the tag.
                    if (bus.is_transmitting) begin
                        r_state <= WAIT_DONE;
                    end else if (r_timeoutCnt == TO_LAST) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.is_transmitting) begin
                        r_remaining <= r_remaining - 1'b1;
                        r_state     <= (r_remaining == LAST_BYTE) ? DONE : ISSUE;
                    end
                end
                DONE: begin
                    r_ack[r_granted] <= 1'b1;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.tx          = r_tx;
    assign bus.txce        = r_txce;
    assign bus.timeout_err = r_timeoutErr;
    assign bus.busy        = (r_state != IDLE);

endmodule
